// File: rtl/dma_pkg.sv
// Shared definitions for the SDRAM<->accelerator DMA engines.
// Covers command addresses, the command word layout and the FSM encoding.
package dma_pkg;

    localparam logic [31:0] CMD_ADDR_RD = 32'h3000_0678;
    localparam logic [31:0] CMD_ADDR_WR = 32'h3000_067C;
    localparam logic [9:0]  DRAM_BASE   = 10'h1E0;

    // CPU command word: bank in [17:16], base byte addr in [15:8], end byte addr in [7:0]
    typedef struct packed {
        logic [13:0] rsvd;
        logic [1:0]  bank;
        logic [7:0]  base;
        logic [7:0]  last;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    function automatic logic [31:0] dram_addr(input logic [1:0] bank, input logic [7:0] addr);
        return {DRAM_BASE, 12'd0, bank, addr};
    endfunction

endpackage

// File: rtl/dma_writeback_if.sv
// SDRAM controller Wishbone slave port; signal names follow the slave's point of view.
interface dma_writeback_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  dram_wbs_stb_i;
    logic                  dram_wbs_cyc_i;
    logic                  dram_wbs_we_i;
    logic [3:0]            dram_wbs_sel_i;
    logic [31:0]           dram_wbs_adr_i;
    logic [DATA_WIDTH-1:0] dram_wbs_dat_i;
    logic                  dram_wbs_ack_o;

    modport master (
        output dram_wbs_stb_i, dram_wbs_cyc_i, dram_wbs_we_i, dram_wbs_sel_i,
        output dram_wbs_adr_i, dram_wbs_dat_i,
        input  dram_wbs_ack_o
    );

    modport slave (
        input  dram_wbs_stb_i, dram_wbs_cyc_i, dram_wbs_we_i, dram_wbs_sel_i,
        input  dram_wbs_adr_i, dram_wbs_dat_i,
        output dram_wbs_ack_o
    );
endinterface

// File: rtl/dma_writeback_fifo.sv
// Result FIFO with show-ahead read; pop and push in the same cycle are legal even when full.
module dma_writeback_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/dma_writeback.sv
// Write-direction DMA: drains accelerator results into SDRAM as single-word Wishbone writes.
// Started by one snooped CPU write carrying bank and byte-address range.
module dma_writeback
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] CMD_ADDR   = CMD_ADDR_WR
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  cpu_wbs_stb_i,
    input  logic                  cpu_wbs_cyc_i,
    input  logic                  cpu_wbs_we_i,
    input  logic [31:0]           cpu_wbs_adr_i,
    input  logic [31:0]           cpu_wbs_dat_i,
    input  logic                  acc_res_valid_i,
    input  logic [DATA_WIDTH-1:0] acc_res_data_i,
    output logic                  acc_res_ready_o,
    dma_writeback_if.master       dram,
    output logic                  busy_o,
    output logic                  done_o
);
    dma_state_e            r_state, w_state_nxt;
    dma_cmd_t              w_cmd;
    logic [1:0]            r_bank;
    logic [5:0]            r_addr;
    logic [5:0]            r_end;
    logic                  r_stb, w_stb_nxt;
    logic [31:0]           r_adr, w_adr_nxt;
    logic [DATA_WIDTH-1:0] r_dat, w_dat_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_cmd_hit;
    logic                  w_ack;
    logic                  w_full, w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_unused;

    assign w_cmd     = dma_cmd_t'(cpu_wbs_dat_i);
    assign w_cmd_hit = cpu_wbs_cyc_i && cpu_wbs_stb_i && cpu_wbs_we_i && (cpu_wbs_adr_i == CMD_ADDR);
    // Only an ack against a strobe we are driving counts
    assign w_ack     = dram.dram_wbs_ack_o && r_stb;
    assign w_unused  = ^{w_cmd.rsvd, w_cmd.base[1:0], w_cmd.last[1:0]};

    assign acc_res_ready_o = !w_full;

    dma_writeback_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) fifo_res (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_push  (acc_res_valid_i && !w_full),
        .i_data  (acc_res_data_i),
        .i_pop   (w_ack),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next state and next values of the registered bus/status outputs
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cmd_hit) w_state_nxt = ST_ARMED;
            ST_ARMED: if (!w_empty)  w_state_nxt = ST_WRITE;
            ST_WRITE: if (w_ack)     w_state_nxt = (r_addr == r_end) ? ST_DONE : ST_ARMED;
            ST_DONE:                 w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase

        w_stb_nxt  = (r_state == ST_WRITE) && !w_ack;
        w_adr_nxt  = w_stb_nxt ? dram_addr(r_bank, {r_addr, 2'b00}) : 32'd0;
        w_dat_nxt  = w_stb_nxt ? w_head : '0;
        w_busy_nxt = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_WRITE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_bank  <= 2'd0;
            r_addr  <= 6'd0;
            r_end   <= 6'd0;
            r_stb   <= 1'b0;
            r_adr   <= 32'd0;
            r_dat   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stb   <= w_stb_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            // Word address counter wraps modulo 256 bytes
            if ((r_state == ST_IDLE) && w_cmd_hit) begin
                r_bank <= w_cmd.bank;
                r_addr <= w_cmd.base[7:2];
                r_end  <= w_cmd.last[7:2];
            end else if (w_ack) begin
                r_addr <= r_addr + 6'd1;
            end
        end
    end

    assign dram.dram_wbs_stb_i = r_stb;
    assign dram.dram_wbs_cyc_i = r_stb;
    assign dram.dram_wbs_we_i  = r_stb;
    assign dram.dram_wbs_sel_i = {4{r_stb}};
    assign dram.dram_wbs_adr_i = r_adr;
    assign dram.dram_wbs_dat_i = r_dat;
    assign busy_o              = r_busy;
    assign done_o              = r_done;

endmodule

// File: tb/tb_dma_writeback.sv
// Directed bench for dma_writeback: Wishbone slave model with programmable wait states,
// write monitor, and hand-computed expected address/data lists.
module tb_dma_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_stb = 1'b0, cpu_cyc = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_adr = 32'd0, cpu_dat = 32'd0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = 32'd0;
    logic        res_ready;
    logic        busy, done;

    always #5 clk = ~clk;

    dma_writeback_if #(.DATA_WIDTH(32)) dram_if ();

    dma_writeback #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CMD_ADDR   (32'h3000_067C)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .cpu_wbs_stb_i   (cpu_stb),
        .cpu_wbs_cyc_i   (cpu_cyc),
        .cpu_wbs_we_i    (cpu_we),
        .cpu_wbs_adr_i   (cpu_adr),
        .cpu_wbs_dat_i   (cpu_dat),
        .acc_res_valid_i (res_valid),
        .acc_res_data_i  (res_data),
        .acc_res_ready_o (res_ready),
        .dram            (dram_if),
        .busy_o          (busy),
        .done_o          (done)
    );

    // Slave model: acks after wait_cfg strobed cycles
    int wait_cfg = 0;
    int wcnt;
    assign dram_if.dram_wbs_ack_o = dram_if.dram_wbs_stb_i && dram_if.dram_wbs_cyc_i && (wcnt >= wait_cfg);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                wcnt <= 0;
        else if (dram_if.dram_wbs_stb_i && !dram_if.dram_wbs_ack_o) wcnt <= wcnt + 1;
        else                                                       wcnt <= 0;
    end

    logic [31:0] got_adr[$], got_dat[$], exp_adr[$], exp_dat[$];
    int          bad_flags = 0, unstable = 0, done_cycles = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_adr, hold_dat;

    // Monitor between edges: record acked writes, bus-shape and stability violations
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (dram_if.dram_wbs_stb_i) begin
                if (dram_if.dram_wbs_sel_i != 4'hF || !dram_if.dram_wbs_we_i || !dram_if.dram_wbs_cyc_i)
                    bad_flags++;
                if (hold_v && (dram_if.dram_wbs_adr_i != hold_adr || dram_if.dram_wbs_dat_i != hold_dat))
                    unstable++;
                if (dram_if.dram_wbs_ack_o) begin
                    got_adr.push_back(dram_if.dram_wbs_adr_i);
                    got_dat.push_back(dram_if.dram_wbs_dat_i);
                    hold_v = 1'b0;
                end else begin
                    hold_v   = 1'b1;
                    hold_adr = dram_if.dram_wbs_adr_i;
                    hold_dat = dram_if.dram_wbs_dat_i;
                end
            end else begin
                hold_v = 1'b0;
                if (dram_if.dram_wbs_cyc_i || dram_if.dram_wbs_adr_i != 0 || dram_if.dram_wbs_dat_i != 0)
                    bad_flags++;
            end
            if (done) begin
                done_cycles++;
                if (busy) bad_flags++;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] d);
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h3000_067C; cpu_dat = d;
        @(negedge clk);
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; cpu_adr = 32'd0; cpu_dat = 32'd0;
    endtask

    task automatic push(input logic [31:0] d);
        bit acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            res_valid = 1'b1;
            res_data  = d;
            acc       = res_ready;
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        check($sformatf("push_%08h", d), 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic start_test();
        got_adr.delete(); got_dat.delete(); exp_adr.delete(); exp_dat.delete();
        bad_flags = 0; unstable = 0; done_cycles = 0;
    endtask

    task automatic end_test(input string tag, input int exp_done);
        check({tag, "_nwrites"}, 32'(got_adr.size()), 32'(exp_adr.size()));
        for (int i = 0; i < exp_adr.size() && i < got_adr.size(); i++) begin
            check($sformatf("%s_adr%0d", tag, i), got_adr[i], exp_adr[i]);
            check($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_dat[i]);
        end
        check({tag, "_busflags"}, 32'(bad_flags), 32'd0);
        check({tag, "_stable"}, 32'(unstable), 32'd0);
        check({tag, "_done_cycles"}, 32'(done_cycles), 32'(exp_done));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_adr.push_back(a);
        exp_dat.push_back(d);
    endtask

    initial begin
        bit seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stb",   32'(dram_if.dram_wbs_stb_i), 32'd0);
        check("rst_cyc",   32'(dram_if.dram_wbs_cyc_i), 32'd0);
        check("rst_sel",   32'(dram_if.dram_wbs_sel_i), 32'd0);
        check("rst_adr",   dram_if.dram_wbs_adr_i, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ready", 32'(res_ready), 32'd1);

        // 1: bank 2, 0x00..0x10, five words, zero-wait slave
        start_test();
        send_cmd(32'h0002_0010);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            push(32'hA0 + 32'(i));
            expect_wr(32'h7800_0200 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        wait_done("t1");
        end_test("t1", 1);

        // 2: fill FIFO before the command, then a single-word transfer
        start_test();
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        @(negedge clk);
        check("t2_ready_full", 32'(res_ready), 32'd0);
        send_cmd(32'h0000_2020);
        expect_wr(32'h7800_0020, 32'hB0);
        wait_done("t2");
        check("t2_ready_back", 32'(res_ready), 32'd1);
        end_test("t2", 1);

        // 3: address wrap 0xF8..0x04; leftover B1..B3 go first
        start_test();
        send_cmd(32'h0001_F804);
        push(32'hC0);
        expect_wr(32'h7800_01F8, 32'hB1);
        expect_wr(32'h7800_01FC, 32'hB2);
        expect_wr(32'h7800_0100, 32'hB3);
        expect_wr(32'h7800_0104, 32'hC0);
        wait_done("t3");
        end_test("t3", 1);

        // 4: slave inserts three wait states per write
        start_test();
        wait_cfg = 3;
        send_cmd(32'h0003_0008);
        for (int i = 0; i < 3; i++) begin
            push(32'hD0 + 32'(i));
            expect_wr(32'h7800_0300 + 32'(4 * i), 32'hD0 + 32'(i));
        end
        wait_done("t4");
        end_test("t4", 1);
        wait_cfg = 0;

        // 5: second command while busy is ignored
        start_test();
        push(32'hE0);
        send_cmd(32'h0000_404C);
        send_cmd(32'h0002_0000);
        for (int i = 1; i < 4; i++) push(32'hE0 + 32'(i));
        for (int i = 0; i < 4; i++) expect_wr(32'h7800_0040 + 32'(4 * i), 32'hE0 + 32'(i));
        wait_done("t5");
        repeat (10) @(negedge clk);
        end_test("t5", 1);

        // 6: asynchronous reset while a write is on the bus
        start_test();
        wait_cfg = 5;
        send_cmd(32'h0000_0004);
        push(32'hF0);
        push(32'hF1);
        push(32'hF2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dram_if.dram_wbs_stb_i) seen = 1'b1;
        end
        check("t6_stb_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_stb",  32'(dram_if.dram_wbs_stb_i), 32'd0);
        check("t6_rst_cyc",  32'(dram_if.dram_wbs_cyc_i), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cfg = 0;
        @(negedge clk);
        check("t6_ready", 32'(res_ready), 32'd1);
        check("t6_busy",  32'(busy), 32'd0);
        start_test();
        send_cmd(32'h0000_0000);
        repeat (10) @(negedge clk);
        check("t6_stall_nowr", 32'(got_adr.size()), 32'd0);
        check("t6_stall_busy", 32'(busy), 32'd1);
        push(32'h0000_0C0D);
        expect_wr(32'h7800_0000, 32'h0000_0C0D);
        wait_done("t6");
        end_test("t6", 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
